fft_butterfly_sequencer: RTL and testbench

//  Sequences a complete in-place radix-2 DIT FFT of N=2**LOG2N points: loops stages and butterflies.

---
 rtl/fft_ctrl_pkg.sv | 70 +++++++
 rtl/fft_addr_gen.sv | 43 ++++
 rtl/fft_butterfly_sequencer.sv | 156 +++++++++++++++
 tb/tb_fft_butterfly_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// ============================================================================
// Module : fft_ctrl_pkg
// Brief  : State encoding, per-phase control words and width helpers for the
//          radix-2 DIT FFT butterfly sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ZR_HALF = 3'd2,
    ST_ZR_FULL = 3'd3,
    ST_ZI_HALF = 3'd4,
    ST_ZI_FULL = 3'd5,
    ST_FLUSH   = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  typedef struct packed {
    logic       load1;
    logic       cin1;
    logic       load2;
    logic       cin2;
    logic       w_sel;
    logic       in_en;
    logic [1:0] in_addr;
    logic       out_en;
    logic       out_addr;
  } ctrl_word_t;

  //                                     ld1   ci1   ld2   ci2   wsel  in_en in_addr out_en out_addr
  localparam ctrl_word_t c_cw_idle    = '0;
  localparam ctrl_word_t c_cw_load    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1};
  localparam ctrl_word_t c_cw_zr_half = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
  localparam ctrl_word_t c_cw_zr_full = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
  localparam ctrl_word_t c_cw_zi_half = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
  localparam ctrl_word_t c_cw_zi_full = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0};
  localparam ctrl_word_t c_cw_flush   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};

  function automatic int addr_width(input int log2n);
    return log2n;
  endfunction

  function automatic int tw_width(input int log2n);
    return log2n - 1;
  endfunction

  function automatic int stage_width(input int log2n);
    return $clog2(log2n);
  endfunction

  function automatic ctrl_word_t ctrl_word(input state_t st);
    case (st)
      ST_LOAD:    return c_cw_load;
      ST_ZR_HALF: return c_cw_zr_half;
      ST_ZR_FULL: return c_cw_zr_full;
      ST_ZI_HALF: return c_cw_zi_half;
      ST_ZI_FULL: return c_cw_zi_full;
      ST_FLUSH:   return c_cw_flush;
      default:    return c_cw_idle;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_addr_gen.sv
// ============================================================================
// Module : fft_addr_gen
// Brief  : Combinational (stage, butterfly) -> operand and twiddle addresses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fft_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int  LOG2N = 3,
  localparam int AW    = addr_width(LOG2N),
  localparam int TW    = tw_width(LOG2N),
  localparam int SW    = stage_width(LOG2N)
) (
  input  logic [SW-1:0] i_stage,
  input  logic [TW-1:0] i_bfly,
  output logic [AW-1:0] o_rd_addr_a,
  output logic [AW-1:0] o_rd_addr_b,
  output logic [TW-1:0] o_tw_idx
);

  localparam logic [SW-1:0] c_last_stage = SW'(LOG2N - 1);

  logic [TW-1:0] w_mask;
  logic [TW-1:0] w_j;
  logic [AW-1:0] w_half;
  logic [AW-1:0] w_group;

  // In the last stage 1<<s wraps to 0 in TW bits, so the mask becomes all ones.
  assign w_mask  = (TW'(1) << i_stage) - TW'(1);
  assign w_j     = i_bfly & w_mask;
  assign w_half  = AW'(1) << i_stage;
  assign w_group = AW'(i_bfly >> i_stage);

  assign o_rd_addr_a = ((w_group << 1) << i_stage) | AW'(w_j);
  assign o_rd_addr_b = o_rd_addr_a + w_half;
  assign o_tw_idx    = w_j << (c_last_stage - i_stage);

endmodule

`default_nettype wire

// File: rtl/fft_butterfly_sequencer.sv
// ============================================================================
// Module : fft_butterfly_sequencer
// Brief  : Stage/butterfly sequencer for an in-place radix-2 DIT FFT, driving
//          the 5-phase ACU/RAM control word and operand/write/twiddle addresses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fft_butterfly_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int  LOG2N = 3,
  localparam int AW    = addr_width(LOG2N),
  localparam int TW    = tw_width(LOG2N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  input  logic          abort,
  input  logic          inverse,
  output logic          busy,
  output logic          done,
  output logic          acu_enable,
  output logic          acu_load1,
  output logic          acu_load2,
  output logic          acu_cin1,
  output logic          acu_cin2,
  output logic          w_sel,
  output logic          data_in_en,
  output logic [1:0]    data_in_addr,
  output logic          data_out_en,
  output logic          data_out_addr,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [AW-1:0] wr_addr,
  output logic [TW-1:0] tw_idx,
  output logic          tw_conj
);

  localparam int            SW           = stage_width(LOG2N);
  localparam logic [SW-1:0] c_last_stage = SW'(LOG2N - 1);
  localparam logic [TW-1:0] c_last_bfly  = '1;

  state_t        r_state;
  logic [SW-1:0] r_stage;
  logic [TW-1:0] r_bfly;
  logic [AW-1:0] r_prev_b;
  logic          r_conj;

  logic [AW-1:0] w_addr_a;
  logic [AW-1:0] w_addr_b;
  logic [TW-1:0] w_tw;
  logic          w_active;
  logic          w_strobe;
  ctrl_word_t    w_cw;

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .i_stage     (r_stage),
    .i_bfly      (r_bfly),
    .o_rd_addr_a (w_addr_a),
    .o_rd_addr_b (w_addr_b),
    .o_tw_idx    (w_tw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_stage  <= '0;
      r_bfly   <= '0;
      r_prev_b <= '0;
      r_conj   <= 1'b0;
    end else if (abort && (r_state != ST_IDLE)) begin
      r_state  <= ST_IDLE;
      r_stage  <= '0;
      r_bfly   <= '0;
      r_prev_b <= '0;
      r_conj   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_stage <= '0;
            r_bfly  <= '0;
            r_conj  <= inverse;
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_stage  <= '0;
          r_bfly   <= '0;
          r_prev_b <= '0;
          r_conj   <= 1'b0;
        end
        default: begin
          if (!hold) begin
            case (r_state)
              ST_LOAD:    r_state <= ST_ZR_HALF;
              ST_ZR_HALF: r_state <= ST_ZR_FULL;
              ST_ZR_FULL: r_state <= ST_ZI_HALF;
              ST_ZI_HALF: r_state <= ST_ZI_FULL;
              ST_ZI_FULL: begin
                // B-result of this butterfly is written in the next LOAD or FLUSH.
                r_prev_b <= w_addr_b;
                if (r_bfly == c_last_bfly) begin
                  r_state <= ST_FLUSH;
                end else begin
                  r_bfly  <= r_bfly + TW'(1);
                  r_state <= ST_LOAD;
                end
              end
              ST_FLUSH: begin
                if (r_stage == c_last_stage) begin
                  r_state <= ST_DONE;
                end else begin
                  r_stage <= r_stage + SW'(1);
                  r_bfly  <= '0;
                  r_state <= ST_LOAD;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign w_cw     = ctrl_word(r_state);
  assign w_active = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_strobe = w_active && !hold;

  assign busy          = w_active;
  assign done          = (r_state == ST_DONE);
  assign acu_enable    = w_strobe;
  assign acu_load1     = w_cw.load1 & w_strobe;
  assign acu_load2     = w_cw.load2 & w_strobe;
  assign acu_cin1      = w_cw.cin1 & w_strobe;
  assign acu_cin2      = w_cw.cin2 & w_strobe;
  assign w_sel         = w_cw.w_sel;
  assign data_in_en    = w_cw.in_en & w_strobe;
  assign data_in_addr  = w_cw.in_addr;
  // The first LOAD of a stage has no previous B-result to write.
  assign data_out_en   = w_cw.out_en & w_strobe & !((r_state == ST_LOAD) && (r_bfly == '0));
  assign data_out_addr = w_cw.out_addr;
  assign rd_addr_a     = w_active ? w_addr_a : '0;
  assign rd_addr_b     = w_active ? w_addr_b : '0;
  assign tw_idx        = w_active ? w_tw : '0;
  assign wr_addr       = !w_active ? '0 : ((r_state == ST_ZI_HALF) ? w_addr_a : r_prev_b);
  assign tw_conj       = r_conj;

endmodule

`default_nettype wire

// File: tb/tb_fft_butterfly_sequencer.sv
// ============================================================================
// Module : tb_fft_butterfly_sequencer
// Brief  : Directed scoreboard bench for the FFT butterfly sequencer (LOG2N=3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fft_butterfly_sequencer;

  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int AW    = 3;
  localparam int TW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          abort = 1'b0;
  logic          inverse = 1'b0;
  logic          busy, done, acu_enable, acu_load1, acu_load2, acu_cin1, acu_cin2, w_sel;
  logic          data_in_en, data_out_en, data_out_addr, tw_conj;
  logic [1:0]    data_in_addr;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [TW-1:0] tw_idx;
  logic [24:0]   all_out;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt, done_cnt, flush_cnt;
  logic exp_conj, last_was_flush;
  logic [2*AW+TW-1:0] rd_q[$];
  logic [AW:0]        wr_q[$];

  always #5 clk = ~clk;

  fft_butterfly_sequencer #(.LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort), .inverse(inverse),
    .busy(busy), .done(done), .acu_enable(acu_enable), .acu_load1(acu_load1),
    .acu_load2(acu_load2), .acu_cin1(acu_cin1), .acu_cin2(acu_cin2), .w_sel(w_sel),
    .data_in_en(data_in_en), .data_in_addr(data_in_addr), .data_out_en(data_out_en),
    .data_out_addr(data_out_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_addr(wr_addr), .tw_idx(tw_idx), .tw_conj(tw_conj)
  );

  assign all_out = {busy, done, acu_enable, acu_load1, acu_load2, acu_cin1, acu_cin2, w_sel,
                    data_in_en, data_in_addr, data_out_en, data_out_addr,
                    rd_addr_a, rd_addr_b, wr_addr, tw_idx, tw_conj};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Butterflies enumerated group by group: pair (k+j, k+j+h), twiddle j*N/(2h).
  task automatic push_run();
    for (int s = 0; s < LOG2N; s++) begin
      int h;
      h = 1 << s;
      for (int k = 0; k < N; k += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          logic [AW-1:0] a, b;
          logic [TW-1:0] t;
          a = AW'(k + j);
          b = AW'(k + j + h);
          t = TW'(j * (N / (2 * h)));
          rd_q.push_back({a, b, t});
          wr_q.push_back({a, 1'b0});
          wr_q.push_back({b, 1'b1});
        end
      end
    end
  endtask

  task automatic tick();
    logic [2*AW+TW-1:0] er;
    logic [AW:0]        ew;
    logic               flush_now;
    @(posedge clk);
    #1;
    flush_now = data_out_en && data_out_addr && !data_in_en;
    if (acu_load1 && data_in_en) begin
      chk("rd_q_nonempty", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) begin
        er = rd_q.pop_front();
        chk("rd_addr_a", rd_addr_a, er[7:5]);
        chk("rd_addr_b", rd_addr_b, er[4:2]);
        chk("tw_idx", tw_idx, er[1:0]);
      end
    end
    if (data_out_en) begin
      chk("wr_q_nonempty", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        ew = wr_q.pop_front();
        chk("wr_addr", wr_addr, ew[AW:1]);
        chk("data_out_addr", data_out_addr, ew[0]);
      end
    end
    if (flush_now) begin
      chk("flush_wr_addr", wr_addr, N - 1);
      flush_cnt++;
    end
    if (busy) begin
      busy_cnt++;
      chk("tw_conj_busy", tw_conj, exp_conj);
    end
    if (done) begin
      done_cnt++;
      chk("done_after_flush", last_was_flush, 1);
      chk("done_busy_low", busy, 0);
      chk("tw_conj_done", tw_conj, exp_conj);
    end
    last_was_flush = flush_now;
  endtask

  task automatic begin_run(input logic inv);
    rd_q.delete();
    wr_q.delete();
    push_run();
    busy_cnt = 0;
    done_cnt = 0;
    flush_cnt = 0;
    last_was_flush = 1'b0;
    exp_conj = inv;
    inverse = inv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input int exp_busy, input string tag);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    tick();
    chk({tag, "_idle_outputs"}, all_out, 0);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_rd_q_empty"}, rd_q.size(), 0);
    chk({tag, "_wr_q_empty"}, wr_q.size(), 0);
  endtask

  initial begin
    int k;
    exp_conj = 1'b0;
    last_was_flush = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    flush_cnt = 0;

    // Reset state
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_out, 0);
    start = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_after_reset", all_out, 0);

    // Plain forward run, with a stray start mid-run that must be ignored
    begin_run(1'b0);
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(200, 63, "run1");

    // Hold for 3 cycles in ZR_FULL of the first butterfly of stage 1
    begin_run(1'b0);
    k = 0;
    while (!(flush_cnt == 1 && acu_cin1) && k < 60) begin
      tick();
      k++;
    end
    chk("hold_reached_zr_full", acu_cin1, 1);
    hold = 1'b1;
    repeat (3) begin
      #1;
      chk("hold_strobes", {acu_enable, acu_load1, acu_load2, acu_cin1, acu_cin2,
                           data_in_en, data_out_en}, 0);
      chk("hold_w_sel", w_sel, 1);
      chk("hold_in_addr", data_in_addr, 2'b01);
      chk("hold_rd_addr_a", rd_addr_a, 0);
      chk("hold_rd_addr_b", rd_addr_b, 2);
      chk("hold_busy", busy, 1);
      tick();
    end
    hold = 1'b0;
    #1;
    chk("hold_release_zr_full", acu_cin1, 1);
    run_to_done(200, 66, "hold");

    // Abort (with hold also high) in ZI_HALF of stage 1
    begin_run(1'b1);
    k = 0;
    while (!(flush_cnt == 1 && acu_load1 && w_sel && !data_in_en) && k < 100) begin
      tick();
      k++;
    end
    chk("abort_reached_zi_half", acu_load1 && w_sel && !data_in_en, 1);
    abort = 1'b1;
    hold = 1'b1;
    tick();
    abort = 1'b0;
    hold = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_idle_outputs", all_out, 0);
    repeat (5) tick();
    chk("abort_no_done", done_cnt, 0);
    begin_run(1'b0);
    run_to_done(200, 63, "rerun");

    // Inverse latched at start, input toggled mid-run
    begin_run(1'b1);
    repeat (5) tick();
    inverse = 1'b0;
    repeat (7) tick();
    inverse = 1'b1;
    repeat (3) tick();
    inverse = 1'b0;
    run_to_done(200, 63, "inverse");

    // Asynchronous reset mid-run
    begin_run(1'b1);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_outputs", all_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    done_cnt = 0;
    repeat (5) tick();
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_idle", all_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
